dp_sequencer: RTL
=================

# dp_sequencer

Multicycle control FSM that drives the 16-bit ALU/register-file datapath. It owns the program counter, fetches instruction words through a memory req/ack handshake, decodes them into datapath controls (`alucont`, `ra1`, `ra2`, `regwrite`), and sequences loads, stores and conditional branches. It sits between the instruction/data memory port and the datapath, one instance per core.

## Interface
- `WIDTH`, 16: datapath and PC width.
- `REGBITS`, 5: register address width; 4-bit instruction fields are zero-extended.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, valid with `mem_req`.
- `mem_addr` out WIDTH: memory address.
- `mem_ack` in 1: access complete; read data valid this cycle.
- `mem_rdata` in 16: instruction or load data.
- `instr` out 16: instruction register, fed to datapath `instructionReg`.
- `alucont` out 6: ALU operation select.
- `ra1`, `ra2` out REGBITS: register read addresses.
- `regwrite` out 1: register-file write enable, one-cycle pulse.
- `wb_sel` out 1: 0 = ALU result, 1 = `mem_rdata` to write port.
- `imm_sel` out 1: 1 = sign-extended `instr[7:0]` replaces rd2.
- `psr_flags` in WIDTH: datapath flags; bit0 C, bit1 Z, bit2 N.
- `pc` out WIDTH: program counter.
- `halted` out 1: high in HALT.

## Operation
- Encoding: `op=instr[15:12]`, `rd=[11:8]`, `ext=[7:4]`, `rs=[3:0]`, `imm8=[7:0]`.
- op 0000: R-type. `alucont={2'b00,ext}`, ra1=rd, ra2=rs, regwrite in EXEC.
- op 0100, ext 0000: LOAD rd <= mem[rs]. ext 0100: STOR mem[rs] <= rd. Other ext values: NOP.
- op 1100: Bcond, cond=rd, disp=imm8. Cond 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 1110 always; all others never taken.
- `instr==16'hFFFF`: HALT.
- Any other op: I-type ALU. `alucont={2'b01,op}`, imm_sel=1, ra1=rd, regwrite in EXEC.
- States and transitions:
  - FETCH: mem_req=1, mem_addr=pc, mem_we=0. On mem_ack, load instr and go to DECODE.
  - DECODE: one cycle. HALT word goes to HALT; otherwise EXEC.
  - EXEC: ALU ops pulse regwrite and set pc<=pc+1, then FETCH. LOAD/STOR go to MEM. Bcond sets pc<=pc+sext(disp) if taken, else pc+1, then FETCH.
  - MEM: mem_req=1, mem_addr=rd1 of rs; mem_we=1 for STOR. On ack: LOAD goes to WB, STOR sets pc+1 and goes to FETCH.
  - WB: regwrite=1, wb_sel=1, pc<=pc+1, then FETCH.
  - HALT: absorbing until reset.
- PC arithmetic is modulo 2^WIDTH; wraps from 16'hFFFF to 0.
- ra1/ra2 are held from DECODE through WB so rd1/rd2 are stable during MEM.

## Timing
- Reset values: state FETCH, pc 0, instr 16'h0000, mem_req 0, mem_we 0, regwrite 0, wb_sel 0, imm_sel 0, alucont 0, ra1/ra2 0, halted 0. mem_req asserts the first cycle after reset release.
- Zero-wait memory (ack in the request cycle): ALU/Bcond take 3 cycles; STOR takes 4; LOAD takes 5.
- Each wait cycle adds one cycle. mem_req and mem_addr stay stable until ack. Ack while mem_req=0 is ignored.
- regwrite is high for exactly one cycle per writing instruction and never during FETCH/DECODE.
- Flags are sampled in EXEC and reflect the previous ALU instruction.
- Reset mid-access: all outputs return to reset values asynchronously, and a pending ack is dropped.

## Configuration
- `DP_SEQ_BCOND_EN` defined: Bcond behaves as specified.
- Undefined: op 1100 decodes as NOP (pc+1, no regwrite), and psr_flags is unused.

## Structure
- Package `dp_ctrl_pkg`: state enum, opcode/ext constants, cond codes, flag bit indices, the HALT word, and `alucont` prefix constants.
- Sub-module `dp_decode`: combinational instr → {alucont, ra1, ra2, imm_sel, class}. The FSM and PC stay in `dp_sequencer`.

## Test plan
- Reset, then R-type `16'h0152`: alucont=6'h05, ra1=1, ra2=2, single regwrite pulse, pc=1 after 3 cycles.
- LOAD `16'h4304` with mem_ack delayed 2 cycles: mem_req held with stable addr; WB regwrite with wb_sel=1; pc+1.
- Bcond `16'hC0FE` with Z=1 at pc=10: pc becomes 8. With Z=0: pc becomes 11. With the macro off: pc becomes 11 in both cases.
- pc=16'hFFFF executing an ALU op: pc wraps to 0.
- `16'hFFFF` fetched: halted=1, mem_req stays 0 indefinitely.
- Reset asserted during MEM wait: outputs immediately at reset values; fetch restarts at pc 0.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and encodings for the multicycle datapath sequencer (dp_sequencer, dp_decode).
// Branch evaluation is only used when DP_SEQ_BCOND_EN is defined.
package dp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU,
      CL_LOAD,
      CL_STOR,
      CL_BCOND,
      CL_NOP,
      CL_HALT
   } iclass_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_LDST  = 4'h4;
   localparam logic [3:0] OP_BCOND = 4'hC;

   localparam logic [3:0] EXT_LOAD = 4'h0;
   localparam logic [3:0] EXT_STOR = 4'h4;

   localparam logic [3:0] COND_Z  = 4'h0;
   localparam logic [3:0] COND_NZ = 4'h1;
   localparam logic [3:0] COND_C  = 4'h2;
   localparam logic [3:0] COND_NC = 4'h3;
   localparam logic [3:0] COND_N  = 4'h4;
   localparam logic [3:0] COND_NN = 4'h5;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;

   localparam logic [15:0] HALT_WORD = 16'hFFFF;

   localparam logic [1:0] ALU_PFX_R = 2'b00;
   localparam logic [1:0] ALU_PFX_I = 2'b01;

   // Unlisted condition codes are never taken.
   function automatic logic cond_taken(input logic [3:0] cond, input logic c,
                                       input logic z, input logic n);
      logic taken;
      case (cond)
         COND_Z:  taken = z;
         COND_NZ: taken = !z;
         COND_C:  taken = c;
         COND_NC: taken = !c;
         COND_N:  taken = n;
         COND_NN: taken = !n;
         COND_AL: taken = 1'b1;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/dp_decode.sv
// Combinational instruction decoder: instruction word -> ALU select, register addresses, class.
// Op 1100 decodes as a branch only when DP_SEQ_BCOND_EN is defined, otherwise as NOP.
module dp_decode
   import dp_ctrl_pkg::*;
#(
   parameter int REGBITS = 5
) (
   input  logic [15:0]        instr,
   output logic [5:0]         alucont,
   output logic [REGBITS-1:0] ra1,
   output logic [REGBITS-1:0] ra2,
   output logic               imm_sel,
   output iclass_t            iclass
);

   logic [3:0] op;
   logic [3:0] rd;
   logic [3:0] ext;
   logic [3:0] rs;

   assign op  = instr[15:12];
   assign rd  = instr[11:8];
   assign ext = instr[7:4];
   assign rs  = instr[3:0];

   always_comb begin
      alucont = {ALU_PFX_I, op};
      ra1     = {{(REGBITS-4){1'b0}}, rd};
      ra2     = {{(REGBITS-4){1'b0}}, rs};
      imm_sel = 1'b1;
      iclass  = CL_ALU;
      if (instr == HALT_WORD) begin
         alucont = '0;
         imm_sel = 1'b0;
         iclass  = CL_HALT;
      end else begin
         case (op)
            OP_RTYPE: begin
               alucont = {ALU_PFX_R, ext};
               imm_sel = 1'b0;
            end
            OP_LDST: begin
               // rs supplies the address on port 1, rd the store data on port 2
               alucont = '0;
               imm_sel = 1'b0;
               ra1     = {{(REGBITS-4){1'b0}}, rs};
               ra2     = {{(REGBITS-4){1'b0}}, rd};
               if (ext == EXT_LOAD)
                  iclass = CL_LOAD;
               else if (ext == EXT_STOR)
                  iclass = CL_STOR;
               else
                  iclass = CL_NOP;
            end
            OP_BCOND: begin
               alucont = '0;
               imm_sel = 1'b0;
`ifdef DP_SEQ_BCOND_EN
               iclass  = CL_BCOND;
`else
               iclass  = CL_NOP;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dp_sequencer.sv
// Multicycle control FSM for the 16-bit ALU/register-file datapath: PC, fetch, decode, load/store, branch.
// Conditional branches are enabled by defining DP_SEQ_BCOND_EN.
module dp_sequencer
   import dp_ctrl_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req,
   output logic               mem_we,
   output logic [WIDTH-1:0]   mem_addr,
   input  logic               mem_ack,
   input  logic [15:0]        mem_rdata,
   input  logic [WIDTH-1:0]   rd1,
   output logic [15:0]        instr,
   output logic [5:0]         alucont,
   output logic [REGBITS-1:0] ra1,
   output logic [REGBITS-1:0] ra2,
   output logic               regwrite,
   output logic               wb_sel,
   output logic               imm_sel,
   input  logic [WIDTH-1:0]   psr_flags,
   output logic [WIDTH-1:0]   pc,
   output logic               halted
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic [15:0]      instr_reg, instr_next;
   logic             mem_req_reg, mem_req_next;
   logic             mem_we_reg, mem_we_next;
   logic             regwrite_reg, regwrite_next;
   logic             wb_sel_reg, wb_sel_next;

   iclass_t          iclass;
   logic             ack_ok;
   logic             br_taken;
   logic             unused_flags;
   logic [WIDTH-1:0] disp_sext;

   // Decoding straight from the instruction register keeps ra1/ra2 stable from DECODE through WB.
   dp_decode #(
      .REGBITS (REGBITS)
   ) u_decode (
      .instr   (instr_reg),
      .alucont (alucont),
      .ra1     (ra1),
      .ra2     (ra2),
      .imm_sel (imm_sel),
      .iclass  (iclass)
   );

   assign ack_ok    = mem_req_reg & mem_ack;
   assign disp_sext = {{(WIDTH-8){instr_reg[7]}}, instr_reg[7:0]};

`ifdef DP_SEQ_BCOND_EN
   assign br_taken     = cond_taken(instr_reg[11:8], psr_flags[FLAG_C],
                                    psr_flags[FLAG_Z], psr_flags[FLAG_N]);
   assign unused_flags = ^psr_flags[WIDTH-1:3];
`else
   assign br_taken     = 1'b0;
   assign unused_flags = ^psr_flags;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_FETCH;
         pc_reg       <= '0;
         instr_reg    <= '0;
         mem_req_reg  <= 1'b0;
         mem_we_reg   <= 1'b0;
         regwrite_reg <= 1'b0;
         wb_sel_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         instr_reg    <= instr_next;
         mem_req_reg  <= mem_req_next;
         mem_we_reg   <= mem_we_next;
         regwrite_reg <= regwrite_next;
         wb_sel_reg   <= wb_sel_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      instr_next    = instr_reg;
      regwrite_next = 1'b0;
      wb_sel_next   = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            if (ack_ok) begin
               instr_next = mem_rdata;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (iclass == CL_HALT) begin
               state_next = ST_HALT;
            end else begin
               state_next    = ST_EXEC;
               regwrite_next = (iclass == CL_ALU);
            end
         end
         ST_EXEC: begin
            case (iclass)
               CL_LOAD, CL_STOR: state_next = ST_MEM;
               CL_BCOND: begin
                  pc_next    = br_taken ? (pc_reg + disp_sext) : (pc_reg + WIDTH'(1));
                  state_next = ST_FETCH;
               end
               default: begin
                  pc_next    = pc_reg + WIDTH'(1);
                  state_next = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            if (ack_ok) begin
               if (iclass == CL_STOR) begin
                  pc_next    = pc_reg + WIDTH'(1);
                  state_next = ST_FETCH;
               end else begin
                  state_next    = ST_WB;
                  regwrite_next = 1'b1;
                  wb_sel_next   = 1'b1;
               end
            end
         end
         ST_WB: begin
            pc_next    = pc_reg + WIDTH'(1);
            state_next = ST_FETCH;
         end
         ST_HALT: ;
         default: state_next = ST_FETCH;
      endcase
      // Request strobes are registered so they are low while in reset and rise one cycle after release.
      mem_req_next = (state_next == ST_FETCH) || (state_next == ST_MEM);
      mem_we_next  = (state_next == ST_MEM) && (iclass == CL_STOR);
   end

   assign mem_req  = mem_req_reg;
   assign mem_we   = mem_we_reg;
   assign mem_addr = (state_reg == ST_MEM) ? rd1 : pc_reg;
   assign instr    = instr_reg;
   assign regwrite = regwrite_reg;
   assign wb_sel   = wb_sel_reg;
   assign pc       = pc_reg;
   assign halted   = (state_reg == ST_HALT);

endmodule
